// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: big-endian byte/halfword/word data-memory controller in
// front of a single-ported SRAM with one-cycle read latency. Each access is
// latched in IDLE and played out over ISSUE -> (WAIT) -> RESP. Misaligned
// requests take a one-cycle ERR path and never touch the SRAM.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [0:31]           addr,
    input  logic [0:31]           data_in,
    input  logic                  write_enable,
    input  logic                  mem_byte,
    input  logic                  mem_half_word,
    input  logic                  sign_extend,
    output logic [0:31]           data_out,
    output logic                  ready,
    output logic                  misalign_err,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [0:3]            sram_be,
    output logic [0:31]           sram_wdata,
    input  logic [0:31]           sram_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    // Internal copies use descending numbering: bit 31 is the big-endian MSB,
    // so addr_s[1:0] is the byte offset within a word.
    logic [31:0] addr_s;
    logic [1:0]  size_s;
    logic        misaligned_s;
    logic        unused_addr_s;

    state_t      state_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic        sext_r;
    logic        we_r;

    assign addr_s = addr;
    // Bits above the SRAM range wrap and are deliberately ignored.
    assign unused_addr_s = ^addr_s;

    // Halfwords need an even offset, words an offset of zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic res;
        case (size)
            SZ_HALF: res = lo[0];
            SZ_WORD: res = (lo != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Byte enables, MSB of the result = lane 0 (bits [0:7] of the bus).
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] res;
        case (size)
            SZ_BYTE: begin
                case (lo)
                    2'd0:    res = 4'b1000;
                    2'd1:    res = 4'b0100;
                    2'd2:    res = 4'b0010;
                    2'd3:    res = 4'b0001;
                    default: res = 4'b0000;
                endcase
            end
            SZ_HALF: begin
                if (lo[1]) res = 4'b0011;
                else       res = 4'b1100;
            end
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    // Replicate sub-word store data into every lane so the enables pick it.
    function automatic logic [31:0] store_steer(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {4{data[7:0]}};
            SZ_HALF: res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    // Pull the addressed lane(s) out of a read word and right-justify them.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        if (lo[1]) h = word[15:0];
        else       h = word[31:16];
        case (size)
            SZ_BYTE: res = sext ? {{24{b[7]}}, b} : {24'h000000, b};
            SZ_HALF: res = sext ? {{16{h[15]}}, h} : {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode the access size (byte wins over halfword) and flag misalignment
    always_comb begin
        size_s = SZ_WORD;
        if (mem_byte)           size_s = SZ_BYTE;
        else if (mem_half_word) size_s = SZ_HALF;
        else                    size_s = SZ_WORD;
        misaligned_s = is_misaligned(size_s, addr_s[1:0]);
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= IDLE;
            size_r       <= SZ_WORD;
            lane_r       <= 2'd0;
            sext_r       <= 1'b0;
            we_r         <= 1'b0;
            data_out     <= 32'h0000_0000;
            ready        <= 1'b0;
            misalign_err <= 1'b0;
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= {ADDR_WIDTH{1'b0}};
            sram_be      <= 4'b0000;
            sram_wdata   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        if (misaligned_s) begin
                            state_r      <= ERR;
                            ready        <= 1'b1;
                            misalign_err <= 1'b1;
                        end else begin
                            state_r    <= ISSUE;
                            size_r     <= size_s;
                            lane_r     <= addr_s[1:0];
                            sext_r     <= sign_extend;
                            we_r       <= write_enable;
                            sram_en    <= 1'b1;
                            sram_we    <= write_enable;
                            sram_addr  <= addr_s[ADDR_WIDTH+1:2];
                            sram_be    <= lane_enables(size_s, addr_s[1:0]);
                            sram_wdata <= store_steer(data_in, size_s);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    sram_en <= 1'b0;
                    sram_we <= 1'b0;
                    sram_be <= 4'b0000;
                    if (we_r) begin
                        state_r <= RESP;
                        ready   <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    data_out <= load_extract(sram_rdata, size_r, lane_r, sext_r);
                    ready    <= 1'b1;
                    state_r  <= RESP;
                end
                RESP: begin
                    ready        <= 1'b0;
                    misalign_err <= 1'b0;
                    state_r      <= IDLE;
                end
                ERR: begin
                    ready        <= 1'b0;
                    misalign_err <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    ready        <= 1'b0;
                    misalign_err <= 1'b0;
                    sram_en      <= 1'b0;
                    sram_we      <= 1'b0;
                    sram_be      <= 4'b0000;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a byte-addressed reference memory
// predicts every access, a bench SRAM serves the DUT, and one compare process
// checks the DUT outputs against the prediction on every cycle.
module tb_data_mem_ctrl;

    localparam int AW     = 12;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 1 << (AW + 2);

    logic          clock, reset, req, we, mb, mh, se;
    logic [31:0]   addr, din, dout, wdata, rdata;
    logic          ready, merr, sram_en, sram_we;
    logic [AW-1:0] saddr;
    logic [3:0]    be;

    int n_chk, n_pass;

    data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .req(req), .addr(addr), .data_in(din),
        .write_enable(we), .mem_byte(mb), .mem_half_word(mh), .sign_extend(se),
        .data_out(dout), .ready(ready), .misalign_err(merr),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(saddr), .sram_be(be),
        .sram_wdata(wdata), .sram_rdata(rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             n_pass++;
    endtask

    // ---------------- reference helpers ----------------
    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] seed_byte(input int b);
        logic [31:0] w;
        w = seed_word(b / 4);
        return w[8*(3 - (b % 4)) +: 8];
    endfunction

    function automatic int nbytes_of(input logic b, input logic h);
        return b ? 1 : (h ? 2 : 4);
    endfunction

    function automatic int bidx(input logic [31:0] a, input int i);
        return (int'(a[AW+1:0]) + i) % NBYTES;
    endfunction

    function automatic bit misal(input logic [31:0] a, input int n);
        return (int'(a[1:0]) % n) != 0;
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic b, input logic h, input logic w);
        if (misal(a, nbytes_of(b, h))) return 1;
        return w ? 2 : 3;
    endfunction

    function automatic logic [3:0] be_of(input int n, input int off);
        int m;
        m = ((1 << n) - 1) << (4 - n - off);
        return m[3:0];
    endfunction

    function automatic logic [31:0] wdata_of(input logic [31:0] d, input int n);
        if (n == 1) return {4{d[7:0]}};
        if (n == 2) return {2{d[15:0]}};
        return d;
    endfunction

    logic [7:0] ref_mem [NBYTES];

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic s);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[bidx(a, i)]};
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // ---------------- bench SRAM ----------------
    logic [31:0] sram_mem [NWORDS];
    bit          sram_init;

    // Bench SRAM: one-cycle read latency, byte-enabled writes
    always @(posedge clock) begin
        if (!sram_init) begin
            for (int i = 0; i < NWORDS; i++) sram_mem[i] <= seed_word(i);
            sram_init <= 1'b1;
        end else if (sram_en) begin
            if (sram_we) begin
                if (be[3]) sram_mem[saddr][31:24] <= wdata[31:24];
                if (be[2]) sram_mem[saddr][23:16] <= wdata[23:16];
                if (be[1]) sram_mem[saddr][15:8]  <= wdata[15:8];
                if (be[0]) sram_mem[saddr][7:0]   <= wdata[7:0];
            end else begin
                rdata <= sram_mem[saddr];
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit            ref_init, chk_en;
    int            cyc, free_edge, ready_edge, data_edge;
    logic          cur_mis;
    logic [31:0]   pend_data, exp_data, exp_wdata;
    logic          exp_en, exp_we, exp_ready, exp_err;
    logic [3:0]    exp_be;
    logic [AW-1:0] exp_saddr;

    // Predict the outputs that follow this edge from the request timeline
    always @(posedge clock) begin
        cyc    <= cyc + 1;
        chk_en <= 1'b1;
        if (!ref_init) begin
            for (int j = 0; j < NBYTES; j++) ref_mem[j] <= seed_byte(j);
            ref_init <= 1'b1;
        end
        if (!reset) begin
            free_edge  <= cyc + 1;
            ready_edge <= -1;
            data_edge  <= -1;
            cur_mis    <= 1'b0;
            exp_data   <= 32'h0;
            exp_en     <= 1'b0;
            exp_we     <= 1'b0;
            exp_be     <= 4'h0;
            exp_ready  <= 1'b0;
            exp_err    <= 1'b0;
        end else begin
            exp_ready <= (cyc == ready_edge);
            exp_err   <= (cyc == ready_edge) && cur_mis;
            if (cyc == data_edge) exp_data <= pend_data;
            if (req && cyc >= free_edge) begin
                free_edge  <= cyc + lat_of(addr, mb, mh, we) + 1;
                ready_edge <= cyc + lat_of(addr, mb, mh, we) - 1;
                cur_mis    <= misal(addr, nbytes_of(mb, mh));
                if (misal(addr, nbytes_of(mb, mh))) begin
                    exp_ready <= 1'b1;
                    exp_err   <= 1'b1;
                    exp_en    <= 1'b0;
                    exp_we    <= 1'b0;
                    exp_be    <= 4'h0;
                end else begin
                    exp_en    <= 1'b1;
                    exp_we    <= we;
                    exp_be    <= be_of(nbytes_of(mb, mh), int'(addr[1:0]));
                    exp_saddr <= addr[AW+1:2];
                    exp_wdata <= wdata_of(din, nbytes_of(mb, mh));
                    if (we) begin
                        for (int i = 0; i < 4; i++)
                            if (i < nbytes_of(mb, mh))
                                ref_mem[bidx(addr, i)] <= din[8*(nbytes_of(mb, mh)-1-i) +: 8];
                    end else begin
                        data_edge <= cyc + 2;
                        pend_data <= ref_load(addr, nbytes_of(mb, mh), se);
                    end
                end
            end else begin
                exp_en <= 1'b0;
                exp_we <= 1'b0;
                exp_be <= 4'h0;
            end
        end
    end

    // Compare DUT outputs with the model on every cycle
    always @(negedge clock) begin
        if (chk_en) begin
            chk("ready", {31'h0, ready}, {31'h0, exp_ready});
            chk("misalign_err", {31'h0, merr}, {31'h0, exp_err});
            chk("data_out", dout, exp_data);
            chk("sram_en", {31'h0, sram_en}, {31'h0, exp_en});
            chk("sram_we", {31'h0, sram_we}, {31'h0, exp_we});
            chk("sram_be", {28'h0, be}, {28'h0, exp_be});
            if (exp_en) chk("sram_addr", 32'(saddr), 32'(exp_saddr));
            if (exp_en && exp_we) chk("sram_wdata", wdata, exp_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic b, input logic h, input logic s, input bit scramble,
                          output int lat, output logic [3:0] i_be, output logic [AW-1:0] i_addr,
                          output logic [31:0] i_wd, output logic i_we, output logic e_at,
                          output logic en_seen);
        lat = 0; i_be = 4'h0; i_addr = '0; i_wd = 32'h0; i_we = 1'b0; e_at = 1'b0; en_seen = 1'b0;
        addr = a; din = d; we = w; mb = b; mh = h; se = s; req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (sram_en) en_seen = 1'b1;
            if (k == 1) begin
                i_be = be; i_addr = saddr; i_wd = wdata; i_we = sram_we;
            end
            if (ready) begin
                lat  = k;
                e_at = merr;
                break;
            end
            if (scramble) begin
                addr = $urandom(); din = $urandom();
                we = 1'($urandom_range(0, 1)); mb = 1'($urandom_range(0, 1));
                mh = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
            end
        end
        chk("txn_done", {31'h0, lat != 0}, 32'h1);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int            lat;
        logic [3:0]    i_be;
        logic [AW-1:0] i_addr;
        logic [31:0]   i_wd, ra;
        logic          i_we, e_at, en_seen, rb, rh;

        n_chk = 0; n_pass = 0;
        reset = 1'b0; req = 1'b0; addr = 32'h0; din = 32'h0;
        we = 1'b0; mb = 1'b0; mh = 1'b0; se = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_data_out", dout, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_err", {31'h0, merr}, 32'h0);
        chk("rst_sram_en", {31'h0, sram_en}, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // word store 0x10
        do_txn(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("st_word_lat", lat, 32'd2);
        chk("st_word_addr", 32'(i_addr), 32'd4);
        chk("st_word_be", {28'h0, i_be}, 32'hF);
        chk("st_word_we", {31'h0, i_we}, 32'h1);
        chk("st_word_wdata", i_wd, 32'hDEAD_BEEF);
        idle(1);

        // sign-extended byte load of lane 3
        do_txn(32'h10, 32'h1234_56F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        idle(1);
        do_txn(32'h13, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("ld_byte_lat", lat, 32'd3);
        chk("ld_byte_sext", dout, 32'hFFFF_FFF0);
        chk("ld_byte_be", {28'h0, i_be}, 32'h1);
        idle(1);

        // halfword loads, zero- and sign-extended
        do_txn(32'h10, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        idle(1);
        do_txn(32'h12, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("ld_half_zext", dout, 32'h0000_ABCD);
        idle(1);
        do_txn(32'h12, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("ld_half_sext", dout, 32'hFFFF_ABCD);
        idle(1);

        // byte store into lane 1, then word readback
        do_txn(32'h20, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        idle(1);
        do_txn(32'h21, 32'h0000_00A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("st_byte_be", {28'h0, i_be}, 32'h4);
        chk("st_byte_wdata", i_wd, 32'hA5A5_A5A5);
        idle(1);
        do_txn(32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("ld_after_byte_st", dout, 32'h11A5_3344);
        idle(1);

        // misaligned halfword
        do_txn(32'h11, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("misal_lat", lat, 32'd1);
        chk("misal_err", {31'h0, e_at}, 32'h1);
        chk("misal_no_sram", {31'h0, en_seen}, 32'h0);
        chk("misal_data_kept", dout, 32'h11A5_3344);
        idle(1);

        // reset while a load is in WAIT
        addr = 32'h20; din = 32'h0; we = 1'b0; mb = 1'b0; mh = 1'b0; se = 1'b0; req = 1'b1;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("rst_wait_ready", {31'h0, ready}, 32'h0);
        chk("rst_wait_data", dout, 32'h0);
        reset = 1'b1;
        idle(3);
        chk("rst_wait_no_late_ready", {31'h0, ready}, 32'h0);
        do_txn(32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
        chk("post_rst_lat", lat, 32'd3);
        chk("post_rst_data", dout, 32'h11A5_3344);
        idle(1);

        // randomized traffic, inputs scrambled while busy, random back-to-back
        for (int t = 0; t < 300; t++) begin
            ra = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 127));
            rb = ($urandom_range(0, 2) == 0);
            rh = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) < 8) begin
                if (!rb && rh)  ra[0] = 1'b0;
                if (!rb && !rh) ra[1:0] = 2'b00;
            end
            do_txn(ra, $urandom(), 1'($urandom_range(0, 1)), rb, rh, 1'($urandom_range(0, 1)), 1'b1,
                   lat, i_be, i_addr, i_wd, i_we, e_at, en_seen);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
